// File: rtl/lsu_stbuf_pkg.sv
// Shared types for the load/store unit and its posted store buffer.
// Entry field widths are fixed here; the top's AW/DW parameters must match them.
package lsu_stbuf_pkg;

    localparam int STB_AW = 16;
    localparam int STB_DW = 16;

    // One buffered store: word address plus data.
    typedef struct packed {
        logic [STB_AW-1:0] addr;
        logic [STB_DW-1:0] data;
    } stbuf_entry_t;

    // Memory-side sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ST_REQ = 2'd1,
        LD_REQ = 2'd2,
        LD_RSP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_stbuf_fifo.sv
// Store buffer storage: circular FIFO with extra-MSB pointers and a parallel
// address search that reports the youngest valid matching entry.
module lsu_stbuf_fifo
    import lsu_stbuf_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  stbuf_entry_t      i_push_entry,
    input  logic              i_pop,
    input  logic [STB_AW-1:0] i_search_addr,
    output stbuf_entry_t      o_head,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_more_than_one,
    output logic              o_hit,
    output logic [STB_DW-1:0] o_hit_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    stbuf_entry_t  r_mem [DEPTH];

    logic [PW-1:0] w_count;
    logic [IW-1:0] w_age [DEPTH];
    logic [DEPTH-1:0] w_match;
    logic [IW-1:0] w_best_age;
    logic          w_hit;
    logic [STB_DW-1:0] w_hit_data;

    assign w_count         = r_wr_ptr - r_rd_ptr;
    assign o_empty         = (r_wr_ptr == r_rd_ptr);
    assign o_full          = (r_wr_ptr[IW] != r_rd_ptr[IW]) &&
                             (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
    assign o_more_than_one = (w_count > PW'(1));
    assign o_head          = r_mem[r_rd_ptr[IW-1:0]];

    // Per-slot age (0 = oldest) and address match against live entries only.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign w_age[gi]   = IW'(gi) - r_rd_ptr[IW-1:0];
        assign w_match[gi] = ({1'b0, w_age[gi]} < w_count) &&
                             (r_mem[gi].addr == i_search_addr);
    end

    // Pick the matching entry with the greatest age, i.e. the youngest store.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match[i] && (!w_hit || (w_age[i] > w_best_age))) begin
                w_hit      = 1'b1;
                w_hit_data = r_mem[i].data;
                w_best_age = w_age[i];
            end
        end
    end

    assign o_hit      = w_hit;
    assign o_hit_data = w_hit_data;

    // Pointer update; push and pop may coincide (count unchanged when full).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Entry storage; contents are don't-care until pointers cover them.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[IW-1:0]] <= i_push_entry;
    end

endmodule

// File: rtl/lsu_stbuf.sv
// Load/store unit with posted store buffer between execute and writeback.
// Optional feature macro: LSU_STBUF_FWD_EN (store-to-load forwarding).
// Without it, a load matching any buffered store waits for the buffer to
// drain past that store before reading memory.
module lsu_stbuf
    import lsu_stbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = STB_AW,
    parameter int DW    = STB_DW
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] mem_addr_ixmem_p1,
    input  logic [DW-1:0] mem_data_in_ixmem_p1,
    input  logic          ldst_valid_ixmem_p1,
    input  logic [1:0]    store_valid_ixmem_p1,
    input  logic [DW-1:0] dest_reg_value_ixmem_p1,
    input  logic [2:0]    dest_reg_index_ixmem_p1,
    input  logic          dest_reg_write_valid_ixmem_p1,
    output logic          stall_memix_p1,
    output logic [DW-1:0] dest_reg_value_memwb_p1,
    output logic [2:0]    dest_reg_index_memwb_p1,
    output logic          dest_reg_write_valid_memwb_p1,
    output logic          dmem_req_p1,
    output logic          dmem_we_p1,
    output logic [AW-1:0] dmem_addr_p1,
    output logic [DW-1:0] dmem_wdata_p1,
    input  logic          dmem_ack_p1,
    input  logic [DW-1:0] dmem_rdata_p1,
    output logic          stbuf_empty_p1
);

    lsu_state_e    r_state;
    lsu_state_e    w_state_next;
    logic [AW-1:0] r_ld_addr;
    logic [DW-1:0] r_wb_value;
    logic [2:0]    r_wb_index;
    logic          r_wb_valid;

    stbuf_entry_t  w_push_entry;
    stbuf_entry_t  w_head;
    logic          w_full, w_empty, w_more_than_one, w_hit;
    logic [DW-1:0] w_hit_data;

    logic w_is_ld, w_is_st, w_in_ld_phase, w_pop, w_push;
    logic w_ld_fwd, w_ld_block, w_ld_wait, w_ld_issue;
    logic w_st_stall, w_stall, w_normal, w_remaining;

    assign w_is_ld       = ldst_valid_ixmem_p1 & ~store_valid_ixmem_p1[0];
    assign w_is_st       = ldst_valid_ixmem_p1 &  store_valid_ixmem_p1[0];
    assign w_in_ld_phase = (r_state == LD_REQ) || (r_state == LD_RSP);
    assign w_pop         = (r_state == ST_REQ) & dmem_ack_p1;

`ifdef LSU_STBUF_FWD_EN
    assign w_ld_fwd   = w_is_ld & w_hit & ~w_in_ld_phase;
    assign w_ld_block = 1'b0;
`else
    assign w_ld_fwd   = 1'b0;
    assign w_ld_block = w_is_ld & w_hit;
`endif

    // A load that is neither forwarded nor already being serviced needs memory.
    assign w_ld_wait   = w_is_ld & ~w_ld_fwd & ~w_in_ld_phase;
    assign w_ld_issue  = w_ld_wait & ~w_ld_block;
    // A drain ack in the same cycle frees the slot the store needs.
    assign w_st_stall  = w_is_st & w_full & ~w_pop & ~w_in_ld_phase;
    assign w_push      = w_is_st & ~w_in_ld_phase & (~w_full | w_pop);
    assign w_stall     = (r_state == LD_REQ) | w_ld_wait | w_st_stall;
    // Instruction retires through the ordinary 1-cycle writeback path.
    assign w_normal    = ~w_stall & ~w_in_ld_phase;
    assign w_remaining = w_more_than_one | w_push;

    assign w_push_entry = '{addr: mem_addr_ixmem_p1, data: mem_data_in_ixmem_p1};

    lsu_stbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk             (clk),
        .rst             (rst),
        .i_push          (w_push),
        .i_push_entry    (w_push_entry),
        .i_pop           (w_pop),
        .i_search_addr   (mem_addr_ixmem_p1),
        .o_head          (w_head),
        .o_full          (w_full),
        .o_empty         (w_empty),
        .o_more_than_one (w_more_than_one),
        .o_hit           (w_hit),
        .o_hit_data      (w_hit_data)
    );

    // Next-state: pending loads take precedence over starting a new drain,
    // but a drain request already on the bus always runs to its ack.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_ld_issue)    w_state_next = LD_REQ;
                else if (!w_empty) w_state_next = ST_REQ;
            end
            ST_REQ: begin
                if (dmem_ack_p1)
                    w_state_next = (w_remaining && !w_ld_wait) ? ST_REQ : IDLE;
            end
            LD_REQ: begin
                if (dmem_ack_p1) w_state_next = LD_RSP;
            end
            LD_RSP:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register and load address capture (held stable through LD_REQ).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ld_addr <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && w_ld_issue) r_ld_addr <= mem_addr_ixmem_p1;
        end
    end

    // Writeback register: memory read data, forwarded/ALU value, or a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_value <= '0;
            r_wb_index <= '0;
            r_wb_valid <= 1'b0;
        end else if ((r_state == LD_REQ) && dmem_ack_p1) begin
            r_wb_value <= dmem_rdata_p1;
            r_wb_index <= dest_reg_index_ixmem_p1;
            r_wb_valid <= dest_reg_write_valid_ixmem_p1;
        end else if (w_normal) begin
            r_wb_value <= w_ld_fwd ? w_hit_data : dest_reg_value_ixmem_p1;
            r_wb_index <= dest_reg_index_ixmem_p1;
            r_wb_valid <= dest_reg_write_valid_ixmem_p1 &
                          (~w_is_st | store_valid_ixmem_p1[1]);
        end else begin
            r_wb_value <= '0;
            r_wb_index <= '0;
            r_wb_valid <= 1'b0;
        end
    end

    assign stall_memix_p1                = w_stall;
    assign dest_reg_value_memwb_p1       = r_wb_value;
    assign dest_reg_index_memwb_p1       = r_wb_index;
    assign dest_reg_write_valid_memwb_p1 = r_wb_valid;
    assign stbuf_empty_p1                = w_empty;

    assign dmem_req_p1   = (r_state == ST_REQ) || (r_state == LD_REQ);
    assign dmem_we_p1    = (r_state == ST_REQ);
    assign dmem_addr_p1  = (r_state == ST_REQ) ? w_head.addr :
                           (r_state == LD_REQ) ? r_ld_addr : '0;
    assign dmem_wdata_p1 = (r_state == ST_REQ) ? w_head.data : '0;

endmodule

// File: tb/tb_lsu_stbuf.sv
// Testbench for lsu_stbuf: directed scenarios followed by a randomized run
// scored against a program-order memory model.
module tb_lsu_stbuf;

    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          ldst_valid;
    logic [1:0]    store_valid;
    logic [DW-1:0] dest_val;
    logic [2:0]    dest_idx;
    logic          dest_wv;
    logic          stall;
    logic [DW-1:0] wb_val;
    logic [2:0]    wb_idx;
    logic          wb_wv;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          stb_empty;

    always #5 clk = ~clk;

    lsu_stbuf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .mem_addr_ixmem_p1             (mem_addr),
        .mem_data_in_ixmem_p1          (mem_data),
        .ldst_valid_ixmem_p1           (ldst_valid),
        .store_valid_ixmem_p1          (store_valid),
        .dest_reg_value_ixmem_p1       (dest_val),
        .dest_reg_index_ixmem_p1       (dest_idx),
        .dest_reg_write_valid_ixmem_p1 (dest_wv),
        .stall_memix_p1                (stall),
        .dest_reg_value_memwb_p1       (wb_val),
        .dest_reg_index_memwb_p1       (wb_idx),
        .dest_reg_write_valid_memwb_p1 (wb_wv),
        .dmem_req_p1                   (dmem_req),
        .dmem_we_p1                    (dmem_we),
        .dmem_addr_p1                  (dmem_addr),
        .dmem_wdata_p1                 (dmem_wdata),
        .dmem_ack_p1                   (dmem_ack),
        .dmem_rdata_p1                 (dmem_rdata),
        .stbuf_empty_p1                (stb_empty)
    );

    typedef struct packed { logic [2:0] idx; logic [15:0] val; } wb_t;
    typedef struct packed { logic [15:0] addr; logic [15:0] data; } wr_t;

    int checks = 0;
    int errors = 0;

    logic [15:0] tbmem  [0:255];
    logic [15:0] shadow [0:255];
    wb_t exp_wb[$];
    wr_t exp_wr[$];
    wr_t drain_log[$];
    logic [15:0] read_log[$];

    bit ack_en = 1'b0;
    int ack_pct = 100;
    bit sb_on = 1'b0;

    logic s_stall, s_wbv, s_req, s_we, s_ack;
    logic [15:0] s_wbval, s_addr, s_wdata;
    logic [2:0] s_wbidx;

    function automatic logic [15:0] mem_init(input int a);
        return 16'(a) ^ 16'hA5C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: answer the memory, sample outputs, score, advance to edge+1.
    task automatic cyc();
        wb_t e;
        wr_t w;
        dmem_ack   = dmem_req && ack_en && ($urandom_range(99) < ack_pct);
        dmem_rdata = (dmem_req && !dmem_we) ? tbmem[dmem_addr[7:0]] : 16'h0;
        #1;
        s_stall = stall;   s_wbv = wb_wv;   s_wbval = wb_val; s_wbidx = wb_idx;
        s_req = dmem_req;  s_we = dmem_we;  s_addr = dmem_addr;
        s_wdata = dmem_wdata; s_ack = dmem_ack;
        if (sb_on && s_wbv) begin
            if (exp_wb.size() == 0) chk("wb_unexpected", s_wbv, 1'b0);
            else begin
                e = exp_wb.pop_front();
                chk("wb_idx", s_wbidx, e.idx);
                chk("wb_val", s_wbval, e.val);
            end
        end
        if (s_ack && s_we) begin
            drain_log.push_back('{addr: s_addr, data: s_wdata});
            tbmem[s_addr[7:0]] = s_wdata;
            if (sb_on) begin
                if (exp_wr.size() == 0) chk("drain_unexpected", s_we, 1'b0);
                else begin
                    w = exp_wr.pop_front();
                    chk("drain_addr", s_addr, w.addr);
                    chk("drain_data", s_wdata, w.data);
                end
            end
        end
        if (s_ack && !s_we) read_log.push_back(s_addr);
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
    endtask

    task automatic set_idle();
        ldst_valid = 0; store_valid = 0; mem_addr = 0; mem_data = 0;
        dest_val = 0; dest_idx = 0; dest_wv = 0;
    endtask

    task automatic set_nop(input logic wv, input logic [15:0] v, input logic [2:0] idx);
        set_idle();
        dest_wv = wv; dest_val = v; dest_idx = idx;
    endtask

    task automatic set_st(input logic [15:0] a, input logic [15:0] d, input logic upd,
                          input logic [15:0] v, input logic [2:0] idx, input logic wv);
        ldst_valid = 1; store_valid = {upd, 1'b1}; mem_addr = a; mem_data = d;
        dest_val = v; dest_idx = idx; dest_wv = wv;
    endtask

    task automatic set_ld(input logic [15:0] a, input logic [2:0] idx);
        ldst_valid = 1; store_valid = 2'b00; mem_addr = a; mem_data = 0;
        dest_val = 16'hDEAD; dest_idx = idx; dest_wv = 1;
    endtask

    task automatic drain_all();
        set_idle();
        ack_en = 1; ack_pct = 100;
        for (int k = 0; k < 50 && !stb_empty; k++) cyc();
        cyc();
        chk("drain_empty", stb_empty, 1'b1);
        ack_en = 0;
    endtask

    initial begin
        int dr_k, rd_k, bad, k;
        for (int i = 0; i < 256; i++) tbmem[i] = mem_init(i);
        dmem_ack = 0; dmem_rdata = 0;
        set_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_stall", stall, 0);
        chk("rst_wbv", wb_wv, 0);
        chk("rst_wbval", wb_val, 0);
        chk("rst_wbidx", wb_idx, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_empty", stb_empty, 1);
        rst = 0;
        $display("T0 reset state checked");

        // Single posted store, drained on ack
        set_st(16'h0010, 16'h1234, 0, 16'h0, 3'd0, 0);
        cyc();
        chk("t1_st_stall", s_stall, 0);
        set_idle();
        #1 chk("t1_not_empty", stb_empty, 0);
        cyc();
        chk("t1_req", dmem_req, 1);
        chk("t1_we", dmem_we, 1);
        chk("t1_addr", dmem_addr, 16'h0010);
        chk("t1_wdata", dmem_wdata, 16'h1234);
        ack_en = 1;
        drain_log.delete();
        cyc();
        ack_en = 0;
        chk("t1_drains", drain_log.size(), 1);
        chk("t1_empty", stb_empty, 1);
        chk("t1_req_off", dmem_req, 0);
        $display("T1 store 0x1234 to 0x0010 drained");

        // Writeback path for ALU ops and stores
        set_nop(1, 16'h7777, 3'd2);
        cyc();
        chk("t1b_alu_wbv", wb_wv, 1);
        chk("t1b_alu_val", wb_val, 16'h7777);
        chk("t1b_alu_idx", wb_idx, 2);
        set_st(16'h0011, 16'hCAFE, 1, 16'h4242, 3'd4, 1);
        cyc();
        chk("t1b_upd_wbv", wb_wv, 1);
        chk("t1b_upd_val", wb_val, 16'h4242);
        chk("t1b_upd_idx", wb_idx, 4);
        set_st(16'h0012, 16'hBEEF, 0, 16'h1111, 3'd5, 1);
        cyc();
        chk("t1b_noupd_wbv", wb_wv, 0);
        drain_log.delete();
        drain_all();
        chk("t1b_ndrain", drain_log.size(), 2);
        if (drain_log.size() == 2) begin
            chk("t1b_d0_addr", drain_log[0].addr, 16'h0011);
            chk("t1b_d1_data", drain_log[1].data, 16'hBEEF);
        end
        $display("T1b writeback of ALU op and store-with-update checked");

        // Two stores to the same address, then a load of it
        drain_log.delete(); read_log.delete();
        set_st(16'h0010, 16'hAAAA, 0, 0, 0, 0);
        cyc();
        set_st(16'h0010, 16'hBBBB, 0, 0, 0, 0);
        cyc();
        set_ld(16'h0010, 3'd3);
`ifdef LSU_STBUF_FWD_EN
        cyc();
        chk("t2_fwd_stall", s_stall, 0);
        chk("t2_fwd_wbv", wb_wv, 1);
        chk("t2_fwd_val", wb_val, 16'hBBBB);
        chk("t2_fwd_idx", wb_idx, 3);
        drain_all();
        chk("t2_fwd_reads", read_log.size(), 0);
        chk("t2_fwd_drains", drain_log.size(), 2);
`else
        ack_en = 1; ack_pct = 100;
        bad = 0;
        for (k = 0; k < 40; k++) begin
            cyc();
            if (!s_stall) break;
            if (s_wbv) bad++;
        end
        ack_en = 0;
        chk("t2_stall_drop", s_stall, 0);
        chk("t2_bubbles", bad, 0);
        chk("t2_wbv", s_wbv, 1);
        chk("t2_val", s_wbval, 16'hBBBB);
        chk("t2_idx", s_wbidx, 3);
        chk("t2_drains", drain_log.size(), 2);
        chk("t2_reads", read_log.size(), 1);
        if (read_log.size() == 1) chk("t2_read_addr", read_log[0], 16'h0010);
        set_idle();
        cyc();
        chk("t2_wb_after", wb_wv, 0);
`endif
        $display("T2 load of 0x0010 after two buffered stores checked");

        // Full buffer: fifth store stalls until a drain ack frees a slot
        drain_log.delete();
        ack_en = 0;
        for (int i = 0; i < 4; i++) begin
            set_st(16'h0020 + 16'(i), 16'h5000 + 16'(i), 0, 0, 0, 0);
            cyc();
            chk("t3_fill_stall", s_stall, 0);
        end
        set_st(16'h0024, 16'h5004, 0, 0, 0, 0);
        cyc();
        chk("t3_full_stall", s_stall, 1);
        cyc();
        chk("t3_full_stall2", s_stall, 1);
        ack_en = 1; ack_pct = 100;
        cyc();
        ack_en = 0;
        chk("t3_ack_nostall", s_stall, 0);
        chk("t3_one_drain", drain_log.size(), 1);
        set_st(16'h0025, 16'h5005, 0, 0, 0, 0);
        cyc();
        chk("t3_still_full", s_stall, 1);
        ack_en = 1;
        cyc();
        ack_en = 0;
        chk("t3_sixth_in", s_stall, 0);
        drain_all();
        chk("t3_ndrain", drain_log.size(), 6);
        for (int i = 0; i < drain_log.size() && i < 6; i++)
            chk("t3_order", drain_log[i].data, 16'h5000 + 16'(i));
        $display("T3 full-buffer stall and same-cycle release checked");

        // Load miss while a drain is on the bus
        drain_log.delete(); read_log.delete();
        set_st(16'h0060, 16'h6666, 0, 0, 0, 0);
        cyc();
        set_idle();
        cyc();
        chk("t4_drain_req", dmem_req, 1);
        chk("t4_drain_we", dmem_we, 1);
        set_ld(16'h0040, 3'd5);
        cyc();
        chk("t4_ld_stall", s_stall, 1);
        cyc();
        chk("t4_hold_req", s_req, 1);
        chk("t4_hold_we", s_we, 1);
        chk("t4_hold_addr", s_addr, 16'h0060);
        ack_en = 1; ack_pct = 100;
        dr_k = -1; rd_k = -1; bad = 0;
        for (k = 0; k < 40; k++) begin
            cyc();
            if (s_ack && s_we && dr_k < 0) dr_k = k;
            if (s_ack && !s_we && rd_k < 0) begin
                rd_k = k;
                if (s_wbv) bad++;
            end
            if (!s_stall) break;
        end
        ack_en = 0;
        chk("t4_stall_drop", s_stall, 0);
        chk("t4_drain_first", (dr_k >= 0) && (rd_k > dr_k), 1);
        chk("t4_wb_latency", k - rd_k, 1);
        chk("t4_wbv_at_ack", bad, 0);
        chk("t4_wbv", s_wbv, 1);
        chk("t4_val", s_wbval, mem_init(16'h40));
        chk("t4_idx", s_wbidx, 5);
        if (read_log.size() > 0) chk("t4_read_addr", read_log[0], 16'h0040);
        set_idle();
        cyc();
        $display("T4 load miss behind in-flight drain checked");

        // Reset asserted while a load request is outstanding
        ack_en = 0;
        set_st(16'h0050, 16'h5555, 0, 0, 0, 0);
        cyc();
        set_ld(16'h0030, 3'd6);
        cyc();
        chk("t5_ldreq_req", dmem_req, 1);
        chk("t5_ldreq_we", dmem_we, 0);
        chk("t5_ldreq_addr", dmem_addr, 16'h0030);
        chk("t5_ldreq_nonempty", stb_empty, 0);
        cyc();
        #2 rst = 1;
        #1;
        chk("t5_rst_req", dmem_req, 0);
        chk("t5_rst_empty", stb_empty, 1);
        chk("t5_rst_wbv", wb_wv, 0);
        chk("t5_rst_wbval", wb_val, 0);
        set_idle();
        @(posedge clk);
        #1;
        chk("t5_edge_req", dmem_req, 0);
        chk("t5_edge_empty", stb_empty, 1);
        chk("t5_edge_wbidx", wb_idx, 0);
        rst = 0;
        drain_log.delete();
        ack_en = 1;
        repeat (4) cyc();
        chk("t5_no_drain", drain_log.size(), 0);
        chk("t5_no_stall", s_stall, 0);
        $display("T5 reset during load request checked");

        // Randomized traffic against the program-order model
        for (int i = 0; i < 256; i++) shadow[i] = tbmem[i];
        exp_wb.delete(); exp_wr.delete();
        sb_on = 1; ack_en = 1; ack_pct = 60;
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic [15:0] a, d, v;
            logic [2:0] idx;
            logic wv, upd;
            kind = $urandom_range(9);
            a = 16'h0080 + 16'($urandom_range(7));
            d = 16'($urandom);
            v = 16'($urandom);
            idx = 3'($urandom_range(7));
            wv = 1'($urandom_range(1));
            upd = 1'($urandom_range(1));
            if (kind < 3) begin
                set_nop(wv, v, idx);
                if (wv) exp_wb.push_back('{idx: idx, val: v});
            end else if (kind < 7) begin
                set_st(a, d, upd, v, idx, wv);
                exp_wr.push_back('{addr: a, data: d});
                shadow[a[7:0]] = d;
                if (wv && upd) exp_wb.push_back('{idx: idx, val: v});
            end else begin
                set_ld(a, idx);
                exp_wb.push_back('{idx: idx, val: shadow[a[7:0]]});
            end
            k = 0;
            do begin
                cyc();
                k++;
            end while (s_stall && k < 100);
            if (s_stall) begin
                chk("rnd_timeout", s_stall, 0);
                break;
            end
            $display("R%0d kind=%0d addr=%0h cycles=%0d", n, kind, a, k);
        end
        set_idle();
        for (int i = 0; i < 80; i++) cyc();
        chk("rnd_wb_left", exp_wb.size(), 0);
        chk("rnd_wr_left", exp_wr.size(), 0);
        chk("rnd_empty", stb_empty, 1);
        sb_on = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
